// File: rtl/binary_codec_pkg.sv
// Shared definitions for the binary <-> one-hot codec blocks.
//   - clog2() and in_width(): index width rule, max(1, clog2(SIZE))
//   - occ_state_t: pipeline occupancy encodings EMPTY / ONE / TWO
package binary_codec_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (longint v = 1; v < longint'(n); v = v * 2) begin
            r++;
        end
        return r;
    endfunction

    // SIZE = 1 still needs a one-bit index so that index 1 can be flagged.
    function automatic int in_width(input int size);
        int w;
        w = clog2(size);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/binary_decoder_core.sv
// Combinational binary index -> one-hot decode with out-of-range flag.
// Ports:
//   i_idx     in   IN_W  binary index
//   o_onehot  out  SIZE  one-hot select, all-zero when i_idx >= SIZE
//   o_oor     out  1     1 when i_idx >= SIZE
module binary_decoder_core
    import binary_codec_pkg::*;
#(
    parameter  int SIZE = 16,
    localparam int IN_W = in_width(SIZE)
) (
    input  logic [IN_W-1:0] i_idx,
    output logic [SIZE-1:0] o_onehot,
    output logic            o_oor
);

    logic [31:0] w_idx_ext;

    assign w_idx_ext = 32'(i_idx);

    for (genvar k = 0; k < SIZE; k++) begin : g_dec
        assign o_onehot[k] = (w_idx_ext == 32'(k));
    end

    assign o_oor = (w_idx_ext >= 32'(SIZE));

endmodule

// File: rtl/binary_decoder.sv
// Streaming binary-to-one-hot decoder with AXI-Stream style handshakes.
// One-cycle latency, full throughput, output register plus one skid register.
// Optional feature macro: BINARY_DECODER_ERRCNT_EN enables the saturating
// out-of-range counter on err_count; otherwise err_count is tied to zero.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   i_tdata     in   IN_W  binary index
//   i_tlast     in   1     passed through with the beat
//   i_tvalid    in   1     input valid
//   i_tready    out  1     input ready (registered)
//   o_tdata     out  SIZE  one-hot vector, zero for out-of-range index
//   o_tuser     out  1     index was >= SIZE
//   o_tlast     out  1     copy of i_tlast
//   o_tvalid    out  1     output valid
//   o_tready    in   1     output ready
//   err_count   out  CNT_W saturating count of accepted out-of-range beats
module binary_decoder
    import binary_codec_pkg::*;
#(
    parameter  int SIZE  = 16,
    parameter  int CNT_W = 16,
    localparam int IN_W  = in_width(SIZE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [SIZE-1:0]  o_tdata,
    output logic             o_tuser,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [CNT_W-1:0] err_count
);

    occ_state_t r_state;
    occ_state_t w_next_state;
    logic       r_tready;

    logic w_accept;
    logic w_xfer;
    logic w_load_out;
    logic w_load_skid;
    logic w_skid_to_out;

    logic [SIZE-1:0] w_in_data;
    logic            w_in_oor;

    logic [SIZE-1:0] r_out_data;
    logic            r_out_user;
    logic            r_out_last;
    logic [SIZE-1:0] r_skid_data;
    logic            r_skid_user;
    logic            r_skid_last;

    binary_decoder_core #(
        .SIZE (SIZE)
    ) u_core (
        .i_idx    (i_tdata),
        .o_onehot (w_in_data),
        .o_oor    (w_in_oor)
    );

    assign w_accept = i_tvalid && r_tready;
    assign w_xfer   = o_tvalid && o_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= EMPTY;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_tready <= (w_next_state != TWO);
        end
    end

    // A registered ready that is high guarantees r_state != TWO, so an
    // accept never coincides with a full pipeline.
    always_comb begin
        w_next_state  = r_state;
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next_state = ONE;
                    w_load_out   = 1'b1;
                end
            end
            ONE: begin
                case ({w_accept, w_xfer})
                    2'b10: begin
                        w_next_state = TWO;
                        w_load_skid  = 1'b1;
                    end
                    2'b01: w_next_state = EMPTY;
                    2'b11: w_load_out = 1'b1;
                    default: ;
                endcase
            end
            TWO: begin
                if (w_xfer) begin
                    w_next_state  = ONE;
                    w_skid_to_out = 1'b1;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_user  <= 1'b0;
            r_out_last  <= 1'b0;
            r_skid_data <= '0;
            r_skid_user <= 1'b0;
            r_skid_last <= 1'b0;
        end else begin
            if (w_load_out) begin
                r_out_data <= w_in_data;
                r_out_user <= w_in_oor;
                r_out_last <= i_tlast;
            end else if (w_skid_to_out) begin
                r_out_data <= r_skid_data;
                r_out_user <= r_skid_user;
                r_out_last <= r_skid_last;
            end
            if (w_load_skid) begin
                r_skid_data <= w_in_data;
                r_skid_user <= w_in_oor;
                r_skid_last <= i_tlast;
            end
        end
    end

    assign i_tready = r_tready;
    assign o_tvalid = (r_state != EMPTY);
    assign o_tdata  = r_out_data;
    assign o_tuser  = r_out_user;
    assign o_tlast  = r_out_last;

`ifdef BINARY_DECODER_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_accept && w_in_oor && (r_err_count != '1)) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_binary_decoder.sv
// Self-checking bench for binary_decoder (SIZE = 12, CNT_W = 4).
// A queue-based reference model tracks beats in flight, expected ready and
// the saturating error count.
module tb_binary_decoder;

    localparam int SIZE  = 12;
    localparam int CNT_W = 4;
    localparam int IN_W  = 4;
`ifdef BINARY_DECODER_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct {
        logic [SIZE-1:0] data;
        logic            user;
        logic            last;
    } beat_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  i_tdata;
    logic             i_tlast;
    logic             i_tvalid;
    logic             i_tready;
    logic [SIZE-1:0]  o_tdata;
    logic             o_tuser;
    logic             o_tlast;
    logic             o_tvalid;
    logic             o_tready;
    logic [CNT_W-1:0] err_count;

    beat_t q[$];
    logic  m_ready     = 1'b0;
    int    m_err       = 0;
    logic  m_rst_seen  = 1'b0;
    logic  last_in_fire = 1'b0;
    int    n_vec = 0;
    int    n_err = 0;

    binary_decoder #(
        .SIZE  (SIZE),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .i_tdata   (i_tdata),
        .i_tlast   (i_tlast),
        .i_tvalid  (i_tvalid),
        .i_tready  (i_tready),
        .o_tdata   (o_tdata),
        .o_tuser   (o_tuser),
        .o_tlast   (o_tlast),
        .o_tvalid  (o_tvalid),
        .o_tready  (o_tready),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [SIZE-1:0] ref_onehot(input int idx);
        logic [SIZE-1:0] one;
        one = 1;
        return (idx < SIZE) ? (one << idx) : '0;
    endfunction

    // One clock cycle: drive at the falling edge, update the model at the
    // rising edge, check at the next falling edge.
    task automatic step(input logic rst, input logic iv, input int idx,
                        input logic il, input logic ordy);
        logic  in_fire;
        logic  out_fire;
        beat_t b;
        reset    = rst;
        i_tvalid = iv;
        i_tdata  = IN_W'(idx);
        i_tlast  = il;
        o_tready = ordy;
        in_fire  = !rst && iv && m_ready;
        out_fire = !rst && (q.size() != 0) && ordy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_err      = 0;
            m_ready    = 1'b0;
            m_rst_seen = 1'b1;
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                b.data = ref_onehot(idx);
                b.user = (idx >= SIZE);
                b.last = il;
                q.push_back(b);
                if (b.user && ERRCNT && m_err < (2 ** CNT_W - 1)) m_err++;
            end
            m_ready    = (q.size() < 2);
            m_rst_seen = 1'b0;
        end
        last_in_fire = in_fire;
        @(negedge clk);
        check("i_tready", 32'(i_tready), 32'(m_ready));
        check("o_tvalid", 32'(o_tvalid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            check("o_tdata", 32'(o_tdata), 32'(q[0].data));
            check("o_tuser", 32'(o_tuser), 32'(q[0].user));
            check("o_tlast", 32'(o_tlast), 32'(q[0].last));
        end else if (m_rst_seen) begin
            check("o_tdata_rst", 32'(o_tdata), 32'd0);
            check("o_tuser_rst", 32'(o_tuser), 32'd0);
            check("o_tlast_rst", 32'(o_tlast), 32'd0);
        end
        check("err_count", 32'(err_count), 32'(m_err));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic done;
        reset    = 1'b1;
        i_tvalid = 1'b0;
        i_tdata  = '0;
        i_tlast  = 1'b0;
        o_tready = 1'b0;
        @(negedge clk);

        // Reset held 4 cycles with valid asserted upstream.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("ready_after_reset", 32'(i_tready), 32'd1);

        // Back-to-back stream of every index, including out-of-range ones.
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, i, (i == 15), 1'b1);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Backpressure: 3 held, 7 to skid, 9 held upstream.
        step(1'b0, 1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 7, 1'b1, 1'b0);
        step(1'b0, 1'b1, 9, 1'b0, 1'b0);
        check("bp_ready_low", 32'(i_tready), 32'd0);
        check("bp_head", 32'(o_tdata), 32'h008);
        done = 1'b0;
        for (int n = 0; n < 8 && !done; n++) begin
            step(1'b0, 1'b1, 9, 1'b0, 1'b1);
            done = last_in_fire;
        end
        if (!done) check("bp_accept_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Single out-of-range index.
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 13, 1'b1, 1'b0);
        check("oor_data", 32'(o_tdata), 32'h000);
        check("oor_user", 32'(o_tuser), 32'd1);
        check("oor_count", 32'(err_count), ERRCNT ? 32'd1 : 32'd0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Saturation of the error counter.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 12 + (i % 4), 1'b0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("err_saturated", 32'(err_count), ERRCNT ? 32'hF : 32'd0);

        // Reset with both registers occupied.
        step(1'b0, 1'b1, 2, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4, 1'b0, 1'b0);
        check("full_ready_low", 32'(i_tready), 32'd0);
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("midrst_valid", 32'(o_tvalid), 32'd0);
        check("midrst_err", 32'(err_count), 32'd0);
        step(1'b0, 1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5, 1'b0, 1'b0);
        check("midrst_idx5", 32'(o_tdata), 32'h020);
        step(1'b0, 1'b0, 0, 1'b0, 1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("drained", 32'(o_tvalid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
